// File: rtl/phaser_in_fine_ctrl.sv
// Multi-lane fine-delay tap controller with built-in DQS-find sweep.
// Define PHASER_IN_FINE_CTRL_SATURATE_EN to saturate host tap steps instead of wrapping.
`timescale 1ns/1ps
module phaser_in_fine_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int TAP_WIDTH = 6,
  parameter int FINE_DELAY = 0,
  parameter int PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] DQS_FIND_PATTERN = 3'b001,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                           SYSCLK,
  input  logic                           RSTB,
  input  logic [NUM_LANES-1:0]           LANEMASK,
  input  logic                           FINEENABLE,
  input  logic                           FINEINC,
  input  logic                           COUNTERLOADEN,
  input  logic [TAP_WIDTH-1:0]           COUNTERLOADVAL,
  input  logic                           COUNTERREADEN,
  output logic [TAP_WIDTH-1:0]           COUNTERREADVAL,
  input  logic                           RSTDQSFIND,
  input  logic [NUM_LANES-1:0]           DQSSAMPLE,
  output logic [NUM_LANES*TAP_WIDTH-1:0] TAPVAL,
  output logic [NUM_LANES-1:0]           FINEOVERFLOW,
  output logic [NUM_LANES-1:0]           DQSLANEFOUND,
  output logic                           DQSFOUND,
  output logic                           DQSOUTOFRANGE,
  output logic                           BUSY
);

`ifdef PHASER_IN_FINE_CTRL_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;
  localparam logic [TAP_WIDTH-1:0] TAP_INIT    = TAP_WIDTH'(FINE_DELAY);
  localparam logic [7:0]           PAT8        = 8'(DQS_FIND_PATTERN);
  localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]           SAMPLE_LAST = 8'(PATTERN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_STEP,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [7:0]             r_cnt;
  logic [7:0]             w_cntNext;
  logic [TAP_WIDTH-1:0]   r_tap [NUM_LANES];
  logic [TAP_WIDTH-1:0]   w_tapNext [NUM_LANES];
  logic [NUM_LANES-1:0]   r_overflow;
  logic [NUM_LANES-1:0]   w_ovfNext;
  logic [NUM_LANES-1:0]   r_laneFound;
  logic [NUM_LANES-1:0]   r_match;
  logic                   r_dqsFound;
  logic                   r_outOfRange;
  logic [TAP_WIDTH-1:0]   r_readVal;

  logic                   w_busy;
  logic                   w_hostOk;
  logic                   w_doStep;
  logic                   w_latchFound;
  logic                   w_finish;
  logic                   w_atMax;
  logic                   w_patBit;
  logic [NUM_LANES-1:0]   w_sampleOk;
  logic [NUM_LANES-1:0]   w_matchAcc;
  logic [NUM_LANES-1:0]   w_foundNext;
  logic [NUM_LANES-1:0]   w_finalFound;
  logic [TAP_WIDTH-1:0]   w_readTap;

  assign w_busy   = (r_state == S_SETTLE) || (r_state == S_SAMPLE) || (r_state == S_STEP);
  assign w_hostOk = ~w_busy;

  // Match accumulator restarts on the first sample of each tap position.
  assign w_patBit     = PAT8[r_cnt[2:0]];
  assign w_sampleOk   = ~(DQSSAMPLE ^ {NUM_LANES{w_patBit}});
  assign w_matchAcc   = (r_cnt == 8'd0) ? w_sampleOk : (r_match & w_sampleOk);
  assign w_foundNext  = r_laneFound | w_matchAcc;
  assign w_finalFound = w_latchFound ? w_foundNext : r_laneFound;

  always_comb begin
    w_atMax   = 1'b0;
    w_readTap = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!r_laneFound[i] && (r_tap[i] == TAP_MAX)) w_atMax = 1'b1;
    end
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (LANEMASK[i]) w_readTap = r_tap[i];
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_doStep     = 1'b0;
    w_latchFound = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_stateNext = S_IDLE;
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_stateNext = S_SAMPLE;
          w_cntNext   = 8'd0;
        end else begin
          w_cntNext = r_cnt + 8'd1;
        end
      end
      S_SAMPLE: begin
        if (r_cnt == SAMPLE_LAST) begin
          w_latchFound = 1'b1;
          w_cntNext    = 8'd0;
          if (&w_foundNext) begin
            w_stateNext = S_DONE;
            w_finish    = 1'b1;
          end else begin
            w_stateNext = S_STEP;
          end
        end else begin
          w_cntNext = r_cnt + 8'd1;
        end
      end
      S_STEP: begin
        w_cntNext = 8'd0;
        if (w_atMax) begin
          w_stateNext = S_DONE;
          w_finish    = 1'b1;
        end else begin
          w_stateNext = S_SETTLE;
          w_doStep    = 1'b1;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
    // A find request always (re)starts the sweep, even mid-sweep.
    if (RSTDQSFIND) begin
      w_stateNext  = S_SETTLE;
      w_cntNext    = 8'd0;
      w_doStep     = 1'b0;
      w_latchFound = 1'b0;
      w_finish     = 1'b0;
    end
  end

  // Host commands only reach the taps while the sweep is idle; load beats step.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_tapNext[i] = r_tap[i];
      w_ovfNext[i] = r_overflow[i];
      if (w_hostOk && LANEMASK[i]) begin
        if (COUNTERLOADEN) begin
          w_tapNext[i] = COUNTERLOADVAL;
          w_ovfNext[i] = 1'b0;
        end else if (FINEENABLE) begin
          if (FINEINC) begin
            if (r_tap[i] == TAP_MAX) begin
              w_ovfNext[i] = 1'b1;
              w_tapNext[i] = SATURATE ? TAP_MAX : '0;
            end else begin
              w_tapNext[i] = r_tap[i] + 1'b1;
            end
          end else begin
            if (r_tap[i] == '0) begin
              w_ovfNext[i] = 1'b1;
              w_tapNext[i] = SATURATE ? '0 : TAP_MAX;
            end else begin
              w_tapNext[i] = r_tap[i] - 1'b1;
            end
          end
        end
      end else if (w_doStep && !r_laneFound[i]) begin
        w_tapNext[i] = r_tap[i] + 1'b1;
      end
    end
    if (RSTDQSFIND) w_ovfNext = '0;
  end

  always_ff @(posedge SYSCLK) begin
    if (!RSTB) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RSTB) begin
      for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= TAP_INIT;
      r_overflow   <= '0;
      r_laneFound  <= '0;
      r_match      <= '0;
      r_dqsFound   <= 1'b0;
      r_outOfRange <= 1'b0;
      r_readVal    <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= w_tapNext[i];
      r_overflow <= w_ovfNext;
      if (w_hostOk && COUNTERREADEN) r_readVal <= w_readTap;
      if (r_state == S_SAMPLE) r_match <= w_matchAcc;
      if (w_latchFound) r_laneFound <= w_foundNext;
      if (w_finish) begin
        r_dqsFound   <= &w_finalFound;
        r_outOfRange <= ~(&w_finalFound);
      end
      if (RSTDQSFIND) begin
        r_laneFound  <= '0;
        r_dqsFound   <= 1'b0;
        r_outOfRange <= 1'b0;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_tapOut
      assign TAPVAL[g*TAP_WIDTH +: TAP_WIDTH] = r_tap[g];
    end
  endgenerate

  assign COUNTERREADVAL = r_readVal;
  assign FINEOVERFLOW   = r_overflow;
  assign DQSLANEFOUND   = r_laneFound;
  assign DQSFOUND       = r_dqsFound;
  assign DQSOUTOFRANGE  = r_outOfRange;
  assign BUSY           = w_busy;

endmodule

// File: tb/tb_phaser_in_fine_ctrl.sv
// Randomised self-checking bench for phaser_in_fine_ctrl against a behavioural tap/sweep model.
// Honours PHASER_IN_FINE_CTRL_SATURATE_EN the same way as the design.
`timescale 1ns/1ps
module tb_phaser_in_fine_ctrl;
  localparam int NL   = 4;
  localparam int TW   = 6;
  localparam int FD   = 5;
  localparam int PL   = 3;
  localparam int SC   = 4;
  localparam int TMAX = (1 << TW) - 1;
  localparam int ITER = SC + PL + 1;
`ifdef PHASER_IN_FINE_CTRL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           SYSCLK = 1'b0;
  logic           RSTB = 1'b0;
  logic [NL-1:0]  LANEMASK = '0;
  logic           FINEENABLE = 1'b0;
  logic           FINEINC = 1'b0;
  logic           COUNTERLOADEN = 1'b0;
  logic [TW-1:0]  COUNTERLOADVAL = '0;
  logic           COUNTERREADEN = 1'b0;
  logic [TW-1:0]  COUNTERREADVAL;
  logic           RSTDQSFIND = 1'b0;
  logic [NL-1:0]  DQSSAMPLE = '0;
  logic [NL*TW-1:0] TAPVAL;
  logic [NL-1:0]  FINEOVERFLOW;
  logic [NL-1:0]  DQSLANEFOUND;
  logic           DQSFOUND;
  logic           DQSOUTOFRANGE;
  logic           BUSY;

  phaser_in_fine_ctrl #(
    .NUM_LANES(NL), .TAP_WIDTH(TW), .FINE_DELAY(FD), .PATTERN_LEN(PL),
    .DQS_FIND_PATTERN(3'b001), .SETTLE_CYCLES(SC)
  ) dut (
    .SYSCLK(SYSCLK), .RSTB(RSTB), .LANEMASK(LANEMASK), .FINEENABLE(FINEENABLE),
    .FINEINC(FINEINC), .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
    .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL), .RSTDQSFIND(RSTDQSFIND),
    .DQSSAMPLE(DQSSAMPLE), .TAPVAL(TAPVAL), .FINEOVERFLOW(FINEOVERFLOW),
    .DQSLANEFOUND(DQSLANEFOUND), .DQSFOUND(DQSFOUND), .DQSOUTOFRANGE(DQSOUTOFRANGE), .BUSY(BUSY)
  );

  always #5 SYSCLK = ~SYSCLK;

  int            errors = 0;
  int            checks = 0;
  int            mTap [NL];
  int            matchTap [NL];
  logic [NL-1:0] mOvf;
  logic [NL-1:0] mFound;
  logic          mDqsFound;
  logic          mOor;
  logic [TW-1:0] mRead;
  logic [PL-1:0] pat;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  function automatic logic [NL*TW-1:0] expTaps();
    logic [NL*TW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*TW +: TW] = TW'(mTap[i]);
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NL; i++) mTap[i] = FD;
    mOvf = '0; mFound = '0; mDqsFound = 1'b0; mOor = 1'b0; mRead = '0;
  endtask

  // One idle-controller cycle of host commands, applied to both DUT and model.
  task automatic applyStimulus(input logic [NL-1:0] mask, input logic fe, input logic fi,
                               input logic le, input logic [TW-1:0] lv, input logic re);
    int nxt;
    LANEMASK = mask; FINEENABLE = fe; FINEINC = fi;
    COUNTERLOADEN = le; COUNTERLOADVAL = lv; COUNTERREADEN = re;
    tick();
    LANEMASK = '0; FINEENABLE = 1'b0; FINEINC = 1'b0;
    COUNTERLOADEN = 1'b0; COUNTERLOADVAL = '0; COUNTERREADEN = 1'b0;
    if (re) begin
      mRead = '0;
      for (int i = 0; i < NL; i++) begin
        if (mask[i]) begin
          mRead = TW'(mTap[i]);
          break;
        end
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        if (le) begin
          mTap[i] = int'(lv);
          mOvf[i] = 1'b0;
        end else if (fe) begin
          nxt = mTap[i] + (fi ? 1 : -1);
          if (nxt < 0 || nxt > TMAX) begin
            mOvf[i] = 1'b1;
            if (SAT) nxt = (nxt < 0) ? 0 : TMAX;
            else     nxt = (nxt + TMAX + 1) % (TMAX + 1);
          end
          mTap[i] = nxt;
        end
      end
    end
  endtask

  task automatic randomHost(input int cycles, input string name);
    logic [TW-1:0] lv;
    for (int c = 0; c < cycles; c++) begin
      case ($urandom_range(0, 2))
        0:       lv = '0;
        1:       lv = TW'(TMAX);
        default: lv = TW'($urandom);
      endcase
      applyStimulus(NL'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), lv, 1'($urandom));
      checkOutput({name, "_tap"}, 64'(TAPVAL), 64'(expTaps()));
      checkOutput({name, "_ovf"}, 64'(FINEOVERFLOW), 64'(mOvf));
      checkOutput({name, "_read"}, 64'(COUNTERREADVAL), 64'(mRead));
    end
  endtask

  function automatic logic [PL-1:0] randNoise();
    logic [PL-1:0] w;
    do w = PL'($urandom); while (w == pat);
    return w;
  endfunction

  // Sweep model: all unfound lanes advance together one tap per iteration.
  task automatic runSweep(input string name);
    int            t [NL];
    logic [NL-1:0] f;
    int            n;
    bit            oor;
    bit            done;
    bit            anyMax;
    int            expBusy;
    int            busyCycles;
    int            phase;
    int            k;
    logic [PL-1:0] noise [NL];
    logic [TW-1:0] tv;

    for (int i = 0; i < NL; i++) t[i] = mTap[i];
    f = '0; n = 0; oor = 1'b0; done = 1'b0;
    while (!done) begin
      n++;
      for (int i = 0; i < NL; i++) if (!f[i] && t[i] == matchTap[i]) f[i] = 1'b1;
      if (&f) begin
        done = 1'b1;
      end else begin
        anyMax = 1'b0;
        for (int i = 0; i < NL; i++) if (!f[i] && t[i] == TMAX) anyMax = 1'b1;
        if (anyMax) begin
          oor = 1'b1;
          done = 1'b1;
        end else begin
          for (int i = 0; i < NL; i++) if (!f[i]) t[i]++;
        end
      end
    end
    expBusy = oor ? n * ITER : n * ITER - 1;

    RSTDQSFIND = 1'b1;
    tick();
    RSTDQSFIND = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < NL; i++) noise[i] = '0;
    while (BUSY === 1'b1 && busyCycles < 2000) begin
      phase = busyCycles % ITER;
      if (phase == 0) for (int i = 0; i < NL; i++) noise[i] = randNoise();
      for (int i = 0; i < NL; i++) begin
        tv = TAPVAL[i*TW +: TW];
        if (phase >= SC && phase < SC + PL) begin
          k = phase - SC;
          DQSSAMPLE[i] = (int'(tv) == matchTap[i]) ? pat[k] : noise[i][k];
        end else begin
          DQSSAMPLE[i] = 1'($urandom);
        end
      end
      LANEMASK = NL'($urandom); FINEENABLE = 1'($urandom); FINEINC = 1'($urandom);
      COUNTERLOADEN = 1'($urandom); COUNTERLOADVAL = TW'($urandom); COUNTERREADEN = 1'($urandom);
      tick();
      busyCycles++;
    end
    LANEMASK = '0; FINEENABLE = 1'b0; FINEINC = 1'b0;
    COUNTERLOADEN = 1'b0; COUNTERLOADVAL = '0; COUNTERREADEN = 1'b0; DQSSAMPLE = '0;

    for (int i = 0; i < NL; i++) mTap[i] = t[i];
    mOvf = '0; mFound = f; mDqsFound = &f; mOor = ~(&f);

    checkOutput({name, "_busyLen"}, 64'(busyCycles), 64'(expBusy));
    checkOutput({name, "_laneFound"}, 64'(DQSLANEFOUND), 64'(mFound));
    checkOutput({name, "_found"}, 64'(DQSFOUND), 64'(mDqsFound));
    checkOutput({name, "_oor"}, 64'(DQSOUTOFRANGE), 64'(mOor));
    checkOutput({name, "_taps"}, 64'(TAPVAL), 64'(expTaps()));
    checkOutput({name, "_ovf"}, 64'(FINEOVERFLOW), 64'(mOvf));
    checkOutput({name, "_readHeld"}, 64'(COUNTERREADVAL), 64'(mRead));
    tick();
    checkOutput({name, "_busyLow"}, 64'(BUSY), 64'd0);
    checkOutput({name, "_foundHeld"}, 64'(DQSFOUND), 64'(mDqsFound));
    checkOutput({name, "_oorHeld"}, 64'(DQSOUTOFRANGE), 64'(mOor));
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_taps"}, 64'(TAPVAL), 64'({6'd5, 6'd5, 6'd5, 6'd5}));
    checkOutput({name, "_ovf"}, 64'(FINEOVERFLOW), 64'd0);
    checkOutput({name, "_laneFound"}, 64'(DQSLANEFOUND), 64'd0);
    checkOutput({name, "_found"}, 64'(DQSFOUND), 64'd0);
    checkOutput({name, "_oor"}, 64'(DQSOUTOFRANGE), 64'd0);
    checkOutput({name, "_busy"}, 64'(BUSY), 64'd0);
    checkOutput({name, "_read"}, 64'(COUNTERREADVAL), 64'd0);
  endtask

  initial begin
    pat = 3'b001;
    modelReset();
    RSTB = 1'b0;
    tick();
    tick();
    checkResetState("reset");
    RSTB = 1'b1;

    // Load beats step, then overflow on the loaded lanes.
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b1, 6'd63, 1'b0);
    checkOutput("load63_taps", 64'(TAPVAL), 64'({6'd5, 6'd63, 6'd63, 6'd5}));
    checkOutput("load63_ovf", 64'(FINEOVERFLOW), 64'd0);
    applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    checkOutput("incMax_taps", 64'(TAPVAL), 64'(expTaps()));
    checkOutput("incMax_ovf", 64'(FINEOVERFLOW), 64'(4'b0110));

    applyStimulus(4'b1100, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("readLane2", 64'(COUNTERREADVAL), 64'(mTap[2]));
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("readHold", 64'(COUNTERREADVAL), 64'(mRead));
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    checkOutput("readMask0", 64'(COUNTERREADVAL), 64'd0);

    randomHost(40, "host");

    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    matchTap[0] = 3; matchTap[1] = 7; matchTap[2] = 0; matchTap[3] = 10;
    runSweep("sweepAll");
    checkOutput("sweepAll_tapsConst", 64'(TAPVAL), 64'({6'd10, 6'd0, 6'd7, 6'd3}));

    applyStimulus(4'b1111, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    matchTap[0] = 3; matchTap[1] = 7; matchTap[2] = 0; matchTap[3] = -1;
    runSweep("sweepOor");
    checkOutput("sweepOor_tapsConst", 64'(TAPVAL), 64'({6'd63, 6'd0, 6'd7, 6'd3}));
    checkOutput("sweepOor_laneConst", 64'(DQSLANEFOUND), 64'(4'b0111));

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NL; i++) applyStimulus(NL'(1 << i), 1'b0, 1'b0, 1'b1, TW'($urandom_range(0, 40)), 1'b0);
      for (int i = 0; i < NL; i++) begin
        case ($urandom_range(0, 3))
          0:       matchTap[i] = -1;
          1:       matchTap[i] = $urandom_range(0, TMAX);
          default: matchTap[i] = mTap[i] + $urandom_range(0, 12);
        endcase
      end
      runSweep($sformatf("sweepRnd%0d", r));
      randomHost(8, $sformatf("hostRnd%0d", r));
    end

    // Reset mid-SETTLE with a host step attempted while busy.
    RSTDQSFIND = 1'b1;
    tick();
    RSTDQSFIND = 1'b0;
    LANEMASK = 4'b1111; FINEENABLE = 1'b1; FINEINC = 1'b1;
    tick();
    LANEMASK = '0; FINEENABLE = 1'b0; FINEINC = 1'b0;
    checkOutput("busyIgnore_taps", 64'(TAPVAL), 64'(expTaps()));
    checkOutput("busyIgnore_busy", 64'(BUSY), 64'd1);
    RSTB = 1'b0;
    tick();
    modelReset();
    checkResetState("midReset");
    RSTB = 1'b1;
    tick();
    checkOutput("postReset_busy", 64'(BUSY), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
